rr_arbiter_n: RTL
=================

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter NUM_REQ SHALL default to 4 and set the number of requesters; legal range is 2..32.
REQ-003 Parameter MAX_HOLD SHALL default to 8 and set the maximum grant tenure in cycles; legal range is 2..255.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 Port req SHALL be an input, NUM_REQ bits wide; a high bit means that requester wants or keeps the resource.
REQ-007 Port grant SHALL be a registered output, NUM_REQ bits wide, one-hot or zero.
REQ-008 Port grant_valid SHALL be a registered output, 1 bit wide, equal to the OR of grant.
REQ-009 Port grant_idx SHALL be a registered output, clog2(NUM_REQ) bits wide, holding the binary index of the owner; it is 0 when grant_valid is 0.

Function
REQ-010 The FSM SHALL have two states, IDLE (no owner) and OWNED (one owner).
REQ-011 In IDLE with req nonzero at edge t, the block SHALL enter OWNED and drive grant for the winner from cycle t+1; latency is 1 cycle.
REQ-012 The winner SHALL be the first set req bit found searching from index (last_idx+1) mod NUM_REQ upward with wrap-around, where last_idx is the previous owner.
REQ-013 In OWNED, grant SHALL hold while req[owner] stays 1, and requests from other requesters SHALL NOT preempt it (lock semantics), except as stated in REQ-021.
REQ-014 In OWNED, if req[owner] is 0 at edge t, the block SHALL re-arbitrate in the same edge over the remaining requests, with the old owner at lowest priority.
REQ-015 Under REQ-014, if any request remains, the new grant SHALL appear at t+1 with no idle bubble; otherwise the block SHALL go to IDLE and grant SHALL be 0 at t+1.
REQ-016 last_idx SHALL update only when a new grant is issued, and SHALL keep its value through IDLE periods.
REQ-017 At most one grant bit SHALL be high in any cycle.
REQ-018 grant SHALL never be high for a requester whose req was low at the edge that issued the grant.
REQ-019 req bits that toggle while another requester owns the resource SHALL have no effect until re-arbitration.

Reset
REQ-020 While reset is high at an edge, the block SHALL set grant=0, grant_valid=0, grant_idx=0, state=IDLE, last_idx=NUM_REQ-1 (so that req[0] has first priority), and the hold counter to 0; this includes reset asserted mid-tenure, which takes effect at the next edge regardless of req.

Configuration
REQ-021 With macro RR_ARB_TIMEOUT_EN defined, a hold counter SHALL count cycles of the current tenure.
REQ-022 Under RR_ARB_TIMEOUT_EN, when the hold counter equals MAX_HOLD-1 and any other req bit is set, the next edge SHALL force re-arbitration per REQ-014 with the owner excluded, even if req[owner] is still 1.
REQ-023 Under RR_ARB_TIMEOUT_EN, if no other request is pending at that point, the owner SHALL keep the grant and the counter SHALL saturate at MAX_HOLD-1.
REQ-024 Under RR_ARB_TIMEOUT_EN, the counter SHALL clear on every new grant.
REQ-025 Without RR_ARB_TIMEOUT_EN, no counter SHALL be synthesised and tenure SHALL be unbounded (pure lock).

Verification
REQ-026 The bench SHALL cover reset release with req=4'b1111 and each owner dropping its req for 1 cycle after being granted for 1 cycle -> grant sequence 0001,0010,0100,1000,0001 with no idle cycles.
REQ-027 The bench SHALL cover req=4'b0100 asserted at cycle 5 from IDLE -> grant=0100 and grant_idx=2 at cycle 6, grant_valid=1.
REQ-028 The bench SHALL cover owner 1 holding req while req[3] rises, without the macro -> grant stays 0010 indefinitely; when req[1] falls at edge t, grant=1000 at t+1.
REQ-029 The bench SHALL cover the same stimulus as REQ-028 with RR_ARB_TIMEOUT_EN and MAX_HOLD=8 -> grant moves to 1000 after 8 cycles of tenure, while req[1] is still high.
REQ-030 The bench SHALL cover reset asserted for 1 cycle while grant=0100 -> the next cycle shows grant=0, grant_idx=0, and then req=4'b1111 yields grant=0001.
REQ-031 The bench SHALL cover NUM_REQ=5 with only req[4] and req[0] active and alternately releasing -> grant alternates 10000,00001 (wrap-around), with the one-hot property holding every cycle.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// Round-robin lock arbiter: a grant is held until the owner drops its request.
// Define RR_ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD cycles when others are waiting.
module rr_arbiter_n #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               fsm_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Handshake: req[i] high asks for / keeps the resource; grant is the registered
    // answer one cycle later and stays put until the owner lowers req (or is timed out).

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   grant_idx_nxt;
    logic [IDX_W-1:0]   last_idx, last_idx_nxt;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic               issue;
    logic               timeout;
    int                 scan;
    logic [IDX_W-1:0]   scan_idx;

    assign fsm_state = (state == OWNED);

    // The current owner never competes, so it naturally ends up at lowest priority.
    always_comb begin
        cand = req;
        if (state == OWNED) begin
            cand = req & ~grant;
        end
    end

    // Scan farthest-first so the nearest candidate after last_idx overwrites the rest.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        scan     = 0;
        scan_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan     = (int'(last_idx) + i) % NUM_REQ;
            scan_idx = IDX_W'(scan);
            if (cand[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    assign timeout = (state == OWNED) && (hold_cnt == HOLD_LAST) && (|cand);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (issue) begin
            hold_cnt <= '0;
        end else if (state == OWNED && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        last_idx_nxt  = last_idx;
        issue         = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    issue = 1'b1;
                end
            end
            OWNED: begin
                if (!req[grant_idx] || timeout) begin
                    if (found) begin
                        issue = 1'b1;
                    end else begin
                        state_nxt     = IDLE;
                        grant_nxt     = '0;
                        grant_idx_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (issue) begin
            state_nxt     = OWNED;
            grant_nxt     = NUM_REQ'(1) << pick_idx;
            grant_idx_nxt = pick_idx;
            last_idx_nxt  = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_idx    <= IDX_W'(NUM_REQ - 1);
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_idx   <= grant_idx_nxt;
            last_idx    <= last_idx_nxt;
        end
    end

endmodule
